beat_timing_gen: RTL and testbench

- Beat (timing-pulse) generator upstream of the hardwired controller `cpu`.
- Turns the t3 clock, a start button (qd) and the controller's `short`, `long` and `stop` feedback into one-hot machine-cycle beats w1/w2/w3.
- The controller consumes those beats.
- Also counts completed machine cycles for debug/display.

---
 rtl/beat_timing_gen.sv | 101 ++++++++++
 tb/tb_beat_timing_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/beat_timing_gen.sv
// One-hot machine-cycle beat generator (w1/w2/w3) with a completed-cycle counter.
// Optional single-cycle stepping input `step` is enabled by defining BEAT_STEP_EN.
module beat_timing_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             qd,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
`ifdef BEAT_STEP_EN
  input  logic             step,
`endif
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             running,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2,
    W3   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   qd_prev_q, qd_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             beats_q, beats_d;

  logic qd_s;
  logic qd_pulse;
  logic last_beat;
  logic halt;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], qd};
    qd_s      = sync_q[SYNC_STAGES-1];
    qd_prev_d = qd_s;
    qd_pulse  = qd_s & ~qd_prev_q;
`ifdef BEAT_STEP_EN
    halt      = stop | step;
`else
    halt      = stop;
`endif
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_beat = 1'b0;

    case (state_q)
      IDLE: if (qd_pulse) state_d = W1;
      W1: begin
        // short wins over long when both are asserted
        if (short) last_beat = 1'b1;
        else       state_d   = W2;
      end
      W2: begin
        if (long) state_d   = W3;
        else      last_beat = 1'b1;
      end
      W3:      last_beat = 1'b1;
      default: state_d   = IDLE;
    endcase

    if (last_beat) begin
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      state_d = halt ? IDLE : W1;
    end

    // Beats are registered alongside the state so they line up with it.
    beats_d = {state_d == W1, state_d == W2, state_d == W3};
  end

  always_ff @(posedge t3) begin
    if (clr) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      qd_prev_q <= 1'b0;
      cnt_q     <= '0;
      beats_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      qd_prev_q <= qd_prev_d;
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
    end
  end

  assign w1      = beats_q[2];
  assign w2      = beats_q[1];
  assign w3      = beats_q[0];
  assign running = (state_q != IDLE);
  assign cyc_cnt = cnt_q;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed plus random stimulus against a beat-position reference model of beat_timing_gen.
module tb_beat_timing_gen;
  localparam int SYNC = 2;
  localparam int CNT  = 4;

  logic           t3 = 1'b0;
  logic           clr, qd, short, long, stop, step;
  logic           w1, w2, w3, running;
  logic [CNT-1:0] cyc_cnt;

  int total = 0;
  int bad   = 0;

  // reference model: pos = beat number within the machine cycle, 0 = idle
  int pos;
  int cnt_m;
  bit sync_m[SYNC];
  bit prev_m;

  always #5 t3 = ~t3;

  beat_timing_gen #(.SYNC_STAGES(SYNC), .CNT_W(CNT)) dut (
    .t3(t3), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
`ifdef BEAT_STEP_EN
    .step(step),
`endif
    .w1(w1), .w2(w2), .w3(w3), .running(running), .cyc_cnt(cyc_cnt)
  );

  task automatic model_edge();
    bit pulse, ends, halt_m;
    if (clr) begin
      pos = 0; cnt_m = 0; prev_m = 0;
      for (int i = 0; i < SYNC; i++) sync_m[i] = 0;
    end else begin
      pulse  = sync_m[SYNC-1] && !prev_m;
      prev_m = sync_m[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) sync_m[i] = sync_m[i-1];
      sync_m[0] = qd;
      halt_m = stop;
`ifdef BEAT_STEP_EN
      halt_m = halt_m || step;
`endif
      if (pos == 0) begin
        if (pulse) pos = 1;
      end else begin
        ends = (pos == 1 && short) || (pos == 2 && !long) || (pos == 3);
        if (ends) begin
          cnt_m = (cnt_m + 1) % (1 << CNT);
          pos   = halt_m ? 0 : 1;
        end else begin
          pos = pos + 1;
        end
      end
    end
  endtask

  task automatic tick(input bit c, input bit q, input bit s, input bit l, input bit st,
                      input string tag);
    logic [3:0]     exp_b;
    logic [CNT-1:0] exp_c;
    clr = c; qd = q; short = s; long = l; stop = st;
    @(posedge t3);
    model_edge();
    #1;
    exp_b = {pos == 1, pos == 2, pos == 3, pos != 0};
    exp_c = cnt_m[CNT-1:0];
    total++;
    assert ({w1, w2, w3, running} === exp_b) else begin
      bad++;
      $error("FAIL %s beats: got %b exp %b", tag, {w1, w2, w3, running}, exp_b);
    end
    total++;
    assert (cyc_cnt === exp_c) else begin
      bad++;
      $error("FAIL %s cyc_cnt: got %0d exp %0d", tag, cyc_cnt, exp_c);
    end
  endtask

  initial begin
    clr = 1; qd = 0; short = 0; long = 0; stop = 0; step = 0;
    pos = 0; cnt_m = 0; prev_m = 0;
    for (int i = 0; i < SYNC; i++) sync_m[i] = 0;

    repeat (2)  tick(1, 0, 0, 0, 0, "reset");
    repeat (10) tick(0, 0, 0, 0, 0, "idle");
    // start and run normal cycles
    repeat (10) tick(0, 1, 0, 0, 0, "start");
    // per-cycle length mix
    repeat (3)  tick(0, 1, 1, 0, 0, "short");
    repeat (4)  tick(0, 1, 0, 0, 0, "normal");
    repeat (6)  tick(0, 1, 0, 1, 0, "long");
    repeat (3)  tick(0, 1, 1, 1, 0, "short_prio");
    // halt with qd held, then release and re-press
    repeat (6)  tick(0, 1, 0, 0, 1, "halt");
    repeat (4)  tick(0, 1, 0, 0, 0, "held");
    repeat (3)  tick(0, 0, 0, 0, 0, "release");
    repeat (5)  tick(0, 1, 0, 1, 0, "repress");
    // reset mid-cycle
    tick(1, 1, 0, 1, 0, "clr_mid");
    repeat (4)  tick(0, 0, 0, 0, 0, "post_clr");
    // counter wrap over 16+ normal cycles
    repeat (5)  tick(0, 1, 0, 0, 0, "wrap_start");
    repeat (40) tick(0, 1, 0, 0, 0, "wrap");

    // random phase
    for (int n = 0; n < 600; n++) begin
`ifdef BEAT_STEP_EN
      step = ($urandom_range(0, 7) == 0);
`endif
      tick(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 5) == 0) ? ~qd : qd,
           $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0), "random");
    end
    step = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
